slot_dispatcher: RTL



---
 rtl/slot_dispatch_pkg.sv | 17 +
 rtl/slot_dispatcher_idx_fifo.sv | 60 ++++++
 rtl/slot_dispatcher.sv | 104 ++++++++++
 3 files changed

// File: rtl/slot_dispatch_pkg.sv
// rtl/slot_dispatch_pkg.sv - shared slot constants, FSM state type and one-hot helper
package slot_dispatch_pkg;

    localparam int SLOT_N     = 8;
    localparam int SLOT_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        COOL
    } state_t;

    function automatic logic [SLOT_N-1:0] slot_onehot(input logic [SLOT_IDX_W-1:0] idx);
        return SLOT_N'(1) << idx;
    endfunction

endpackage

// File: rtl/slot_dispatcher_idx_fifo.sv
// rtl/slot_dispatcher_idx_fifo.sv - DEPTH x SLOT_IDX_W index FIFO with flush
module idx_fifo
    import slot_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [SLOT_IDX_W-1:0] push_idx,
    input  logic                  pop,
    output logic [SLOT_IDX_W-1:0] head_idx,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty
);

    logic [SLOT_IDX_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign head_idx = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_idx;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/slot_dispatcher.sv
// rtl/slot_dispatcher.sv - paced one-hot slot command dispatcher with cooldown
// Optional SLOT_DISPATCH_RETRY_EN: busy head is held and retried instead of rejected.
module slot_dispatcher
    import slot_dispatch_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int COOLDOWN = 2,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  flush,
    input  logic                  req_valid,
    input  logic [SLOT_IDX_W-1:0] req_idx,
    output logic                  req_ready,
    input  logic [SLOT_N-1:0]     busy_mask,
    output logic [SLOT_N-1:0]     grant_onehot,
    output logic                  reject,
    output logic [SLOT_IDX_W-1:0] reject_idx,
    output logic [LW-1:0]         level
);

    state_t                state;
    logic [3:0]            cd;
    logic                  full;
    logic                  empty;
    logic [SLOT_IDX_W-1:0] head_idx;
    logic                  head_busy;
    logic                  push_acc;
    logic                  dispatch;
    logic                  pop;
    logic [LW-1:0]         remaining;

    assign req_ready = !full;
    assign push_acc  = req_valid && req_ready && !flush;
    assign head_busy = busy_mask[head_idx];
    assign dispatch  = (state == READY) && tick && !flush && !empty;
`ifdef SLOT_DISPATCH_RETRY_EN
    assign pop = dispatch && !head_busy;
`else
    assign pop = dispatch;
`endif
    // Occupancy after this edge, used to pick READY vs IDLE.
    assign remaining = level - LW'(pop) + LW'(push_acc);

    idx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .push     (push_acc),
        .push_idx (req_idx),
        .pop      (pop),
        .head_idx (head_idx),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cd           <= '0;
            grant_onehot <= '0;
            reject       <= 1'b0;
            reject_idx   <= '0;
        end else begin
            grant_onehot <= '0;
            reject       <= 1'b0;
            if (flush) begin
                state <= IDLE;
                cd    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (push_acc) state <= READY;
                    end
                    READY: begin
                        if (pop) begin
                            if (head_busy) begin
                                reject     <= 1'b1;
                                reject_idx <= head_idx;
                            end else begin
                                grant_onehot <= slot_onehot(head_idx);
                            end
                            cd <= 4'(COOLDOWN);
                            if (COOLDOWN > 0)        state <= COOL;
                            else if (remaining != 0) state <= READY;
                            else                     state <= IDLE;
                        end
                    end
                    COOL: begin
                        if (tick) begin
                            cd <= cd - 1'b1;
                            if (cd == 4'd1) state <= (remaining != 0) ? READY : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
